// File: rtl/seq_mult_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package seq_mult_pkg;

  // Default operand width; the product is twice as wide.
  localparam int unsigned WIDTH_DEFAULT = 24;
  localparam int unsigned PROD_WIDTH_DEFAULT = 2 * WIDTH_DEFAULT;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width of an iteration counter that must reach the value 'width'.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand/accumulator registers and the radix-2 shift-add step.
// load latches fresh operands and clears the accumulator; step performs one
// partial-product iteration. sum_next is the accumulator value this step
// would produce, so the controller can capture the final sum on the last step.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     input0,
  input  logic [WIDTH-1:0]     input1,
  output logic [2*WIDTH-1:0]   sum_next
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mplier_d;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  // Add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    sum_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state selection: load has priority over step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, input0};
      mplier_d = input1;
      acc_d    = '0;
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = sum_next;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/seq_mult24.sv
// Sequential unsigned WIDTH x WIDTH multiplier with start/ready handshake.
// One partial product per clock: accept (E0), WIDTH steps (E1..E24, product
// written on the last), one DONE cycle with ready high, then back to IDLE.
module seq_mult24
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     input0,
  input  logic [WIDTH-1:0]     input1,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   output0
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e             state_q;
  state_e             state_d;
  logic [CntW-1:0]    cnt_q;
  logic [CntW-1:0]    cnt_d;
  logic               ready_q;
  logic               ready_d;
  logic [2*WIDTH-1:0] output0_q;
  logic [2*WIDTH-1:0] output0_d;

  logic               load;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] sum_next;

  seq_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .input0   (input0),
    .input1   (input1),
    .sum_next (sum_next)
  );

  // Datapath enables; start only matters in IDLE.
  always_comb begin
    load = (state_q == StIdle) && start;
    step = (state_q == StBusy);
    last = step && (cnt_q == LastCnt);
  end

  // Controller next state, counter, and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    output0_d = output0_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d   = StDone;
          ready_d   = 1'b1;
          output0_d = sum_next;
        end
      end
      StDone: begin
        // Always return to IDLE so a held start launches one cycle later.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      output0_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      output0_q <= output0_d;
    end
  end

  assign ready   = ready_q;
  assign output0 = output0_q;

endmodule

// File: tb/tb_seq_mult24.sv
// Self-checking bench for seq_mult24: directed and random multiplies checked
// against plain arithmetic and the fixed 25-edge latency.
module tb_seq_mult24;

  localparam int W = 24;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    input0;
  logic [W-1:0]    input1;
  logic            ready;
  logic [2*W-1:0]  output0;

  int checks;
  int failures;

  seq_mult24 #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .input0  (input0),
    .input1  (input1),
    .ready   (ready),
    .output0 (output0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE; optionally scramble inputs while busy.
  // lat counts edges after the accepting edge until ready is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                        output int lat, output logic [2*W-1:0] prod,
                        output logic ready_after, output bit timeout);
    start  = 1'b1;
    input0 = a;
    input1 = b;
    tick();
    start = 1'b0;
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (scramble) begin
        input0 = W'($urandom);
        input1 = W'($urandom);
      end
      tick();
      lat++;
      if (ready) begin
        timeout = 1'b0;
        break;
      end
    end
    prod = output0;
    tick();
    ready_after = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    input0 = 24'h000011;
    input1 = 24'h000022;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", ready);
    end
    checks++;
    if (output0 !== '0) begin
      failures++;
      $display("FAIL reset_output0 got=%h want=0", output0);
    end
    rst = 1'b0;
    // start was dropped together with reset, so nothing may launch.
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (ready !== 1'b0 || output0 !== '0) begin
      failures++;
      $display("FAIL reset_idle ready=%b output0=%h want ready=0 output0=0", ready, output0);
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] want);
    int lat;
    logic [2*W-1:0] prod;
    logic ra;
    bit to;
    run_op(a, b, 1'b0, lat, prod, ra, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s_timeout no ready within 40 edges", name);
    end
    checks++;
    if (lat != 24) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=24 edges after accept", name, lat);
    end
    checks++;
    if (prod !== want) begin
      failures++;
      $display("FAIL %s_product got=%h want=%h", name, prod, want);
    end
    checks++;
    if (ra !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse_width ready still high got=%b want=0", name, ra);
    end
  endtask

  task automatic test_busy_isolation();
    int pulses;
    logic [2*W-1:0] seen;
    start  = 1'b1;
    input0 = 24'h000003;
    input1 = 24'h000005;
    tick();
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 60; i++) begin
      // Toggle start and inputs only while the operation is still iterating.
      if (i < 20) begin
        start  = ~start;
        input0 = W'($urandom);
        input1 = W'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      if (ready) begin
        pulses++;
        seen = output0;
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL busy_pulses got=%0d want=1", pulses);
    end
    checks++;
    if (seen !== 48'hF) begin
      failures++;
      $display("FAIL busy_product got=%h want=%h", seen, 48'hF);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [2*W-1:0] prod;
    logic ra;
    bit to;
    bit bad;
    start  = 1'b1;
    input0 = 24'h00ABCD;
    input1 = 24'h001234;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready !== 1'b0 || output0 !== '0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midop_abort ready/output0 nonzero after reset, last ready=%b output0=%h want 0/0",
               ready, output0);
    end
    run_op(24'h000007, 24'h000009, 1'b0, lat, prod, ra, to);
    checks++;
    if (to || lat != 24 || prod !== 48'h3F) begin
      failures++;
      $display("FAIL midop_next timeout=%0d lat=%0d product=%h want lat=24 product=%h",
               to, lat, prod, 48'h3F);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2*W-1:0] prod;
    logic ra;
    bit to;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (n % 8 == 0) a = '1;
      if (n % 8 == 1) b = '0;
      run_op(a, b, 1'b1, lat, prod, ra, to);
      checks++;
      if (to || lat != 24 || ra !== 1'b0 || prod !== model_mul(a, b)) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got=%h lat=%0d to=%0d want=%h lat=24",
                 n, a, b, prod, lat, to, model_mul(a, b));
      end
    end
  endtask

  // start held high throughout; operands bump on each ready pulse.
  task automatic test_back_to_back();
    logic [W-1:0] cur;
    logic [W-1:0] launched;
    int gap;
    bit first;
    cur = 24'd1;
    launched = cur;
    input0 = cur;
    input1 = cur;
    start = 1'b1;
    first = 1'b1;
    gap = 0;
    for (int n = 0; n < 2000; n++) begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
        tick();
        gap++;
        if (ready) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got || output0 !== model_mul(launched, launched)) begin
        failures++;
        $display("FAIL b2b_product_%0d got=%h want=%h seen=%0d", n, output0,
                 model_mul(launched, launched), got);
      end
      // First pulse: 25 edges including the accepting one; then every 26.
      checks++;
      if (gap != (first ? 25 : 26)) begin
        failures++;
        $display("FAIL b2b_spacing_%0d got=%0d want=%0d", n, gap, first ? 25 : 26);
      end
      if (!got) break;
      first = 1'b0;
      gap = 0;
      cur = cur + 1'b1;
      launched = cur;
      input0 = cur;
      input1 = cur;
    end
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    input0   = '0;
    input1   = '0;
    #1;
    test_reset();
    test_directed("basic", 24'h000001, 24'h000001, 48'h1);
    test_directed("max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    test_directed("zero", 24'h000000, 24'h123456, 48'h0);
    test_busy_isolation();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
